// File: rtl/recompute_pkg.sv
// recompute_pkg: scheduler states, fault coordinate record and width helpers for recompute_unit_scheduler
package recompute_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} sched_state_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int DEF_NUM_RU = 4;
  localparam int DEF_RW = clog2_min1(DEF_ROWS);
  localparam int DEF_CW = clog2_min1(DEF_COLS);
  typedef struct packed {
    logic [DEF_RW-1:0] row;
    logic [DEF_CW-1:0] col;
  } pe_coord_t;
endpackage

// File: rtl/ru_issue_channel.sv
// ru_issue_channel: one RU beat stream sweeping k = 0..COLS-1 over a loaded fault coordinate
module ru_issue_channel #(
  parameter int COLS = 4,
  parameter int RW   = 2,
  parameter int CW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [RW-1:0] i_row,
  input  logic [CW-1:0] i_col,
  input  logic          i_ready,
  output logic          o_valid,
  output logic          o_last,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic [CW-1:0] o_k
);
  logic          r_valid;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col, r_k;
  logic          w_last;
  assign w_last = r_valid && (r_k == CW'(COLS - 1));
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_row   <= i_row;
      r_col   <= i_col;
      r_k     <= '0;
    end else if (r_valid && i_ready) begin
      r_valid <= !w_last;
      r_k     <= w_last ? r_k : r_k + 1'b1;
    end
  assign o_valid = r_valid;
  assign o_last  = w_last;
  assign o_row   = r_row;
  assign o_col   = r_col;
  assign o_k     = r_k;
endmodule

// File: rtl/recompute_unit_scheduler.sv
// recompute_unit_scheduler: scans the STW pass/fail matrix, lists faulty PEs and streams recompute beats to the RU bank.
// RECOMPUTE_MULTI_PASS_EN: list holds every fault and RUs that finish pull further entries.
module recompute_unit_scheduler
  import recompute_pkg::*;
#(
  parameter  int ROWS   = DEF_ROWS,
  parameter  int COLS   = DEF_COLS,
  parameter  int NUM_RU = DEF_NUM_RU,
  localparam int RW     = clog2_min1(ROWS),
  localparam int CW     = clog2_min1(COLS),
  localparam int FW     = $clog2(ROWS * COLS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_start,
  input  logic [ROWS*COLS-1:0] stw_result,
  output logic                 busy,
  output logic                 done,
  output logic [FW-1:0]        fault_count,
  output logic                 overflow,
  output logic [NUM_RU-1:0]    ru_valid,
  input  logic [NUM_RU-1:0]    ru_ready,
  output logic [NUM_RU*RW-1:0] ru_row,
  output logic [NUM_RU*CW-1:0] ru_col,
  output logic [NUM_RU*CW-1:0] ru_k,
  output logic [NUM_RU-1:0]    ru_last
);
  localparam int CELLS = ROWS * COLS;
  localparam int IW    = clog2_min1(CELLS);
`ifdef RECOMPUTE_MULTI_PASS_EN
  localparam int DEPTH = CELLS;
`else
  localparam int DEPTH = NUM_RU;
`endif
  localparam int LW = clog2_min1(DEPTH);
  sched_state_e      r_state, w_state_n;
  logic [IW-1:0]     r_idx;
  logic [FW-1:0]     r_fc, r_next, w_limit, w_take;
  logic              r_ovf, w_fault, w_full;
  logic [RW-1:0]     r_lrow [DEPTH];
  logic [CW-1:0]     r_lcol [DEPTH];
  logic [RW-1:0]     w_srow;
  logic [CW-1:0]     w_scol;
  logic [NUM_RU-1:0] w_load, w_valid;
  logic [LW-1:0]     w_sel [NUM_RU];
  int                w_n;
  assign w_fault = (r_state == SCAN) && !stw_result[r_idx];
  assign w_full  = r_fc >= FW'(DEPTH);
  assign w_limit = w_full ? FW'(DEPTH) : r_fc;
  assign w_srow  = RW'(int'(r_idx) / COLS);
  assign w_scol  = CW'(int'(r_idx) % COLS);
  // idle RUs take consecutive pending entries, lowest RU index first
  always_comb begin
    w_n    = int'(r_next);
    w_load = '0;
    for (int i = 0; i < NUM_RU; i++) begin
      w_sel[i] = LW'(w_n);
      if (r_state == ISSUE && !w_valid[i] && w_n < int'(w_limit)) begin
        w_load[i] = 1'b1;
        w_n       = w_n + 1;
      end
    end
    w_take = FW'(w_n - int'(r_next));
  end
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    w_state_n = scan_start ? SCAN : IDLE;
      SCAN:    if (r_idx == IW'(CELLS - 1)) w_state_n = (r_fc == '0 && !w_fault) ? DONE : ISSUE;
      ISSUE:   if (!(|w_valid) && r_next == w_limit) w_state_n = DONE;
      DONE:    w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_fc    <= '0;
      r_ovf   <= 1'b0;
      r_next  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_lrow[i] <= '0;
        r_lcol[i] <= '0;
      end
    end else begin
      r_state <= w_state_n;
      if (r_state == IDLE && scan_start) begin
        r_idx  <= '0;
        r_fc   <= '0;
        r_ovf  <= 1'b0;
        r_next <= '0;
      end else if (r_state == SCAN) begin
        r_idx <= r_idx + 1'b1;
        if (w_fault) r_fc <= r_fc + 1'b1;
        if (w_fault && w_full) r_ovf <= 1'b1;
        if (w_fault && !w_full) begin
          r_lrow[LW'(r_fc)] <= w_srow;
          r_lcol[LW'(r_fc)] <= w_scol;
        end
      end else begin
        r_next <= r_next + w_take;
      end
    end
  for (genvar i = 0; i < NUM_RU; i++) begin : g_ru
    ru_issue_channel #(.COLS(COLS), .RW(RW), .CW(CW)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[i]),
      .i_row   (r_lrow[w_sel[i]]),
      .i_col   (r_lcol[w_sel[i]]),
      .i_ready (ru_ready[i]),
      .o_valid (w_valid[i]),
      .o_last  (ru_last[i]),
      .o_row   (ru_row[i*RW +: RW]),
      .o_col   (ru_col[i*CW +: CW]),
      .o_k     (ru_k[i*CW +: CW])
    );
  end
  assign ru_valid    = w_valid;
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;
  assign fault_count = r_fc;
  assign overflow    = r_ovf;
endmodule
